// File: rtl/nested_loop_seq.sv
// rtl/nested_loop_seq.sv - two-level loop sequencer with action strobes and totals
// Optional NLS_DONE_CLEAR_EN: clear indices and totals when leaving DONE.
module nested_loop_seq #(
   parameter int CNT_W = 8,
   parameter int ACC_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             pause,
   input  logic [CNT_W-1:0] outer_n,
   input  logic [CNT_W-1:0] inner_n,
   output logic [CNT_W-1:0] x,
   output logic [CNT_W-1:0] y,
   output logic             act1,
   output logic             act2,
   output logic [ACC_W-1:0] act1_cnt,
   output logic [ACC_W-1:0] act2_cnt,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_OUTER = 2'd1,
      S_INNER = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);
   localparam logic [ACC_W-1:0] ONE_A = ACC_W'(1);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] outer_q;
   logic [CNT_W-1:0] inner_q;
   logic             last_x;
   logic             last_y;

   // Bounds are nonzero whenever these compares matter (OUTER/INNER only).
   assign last_x = (x == (outer_q - ONE_C));
   assign last_y = (y == (inner_q - ONE_C));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = (outer_n == '0) ? S_DONE : S_OUTER;
            end
         end
         S_OUTER: begin
            if (!pause) begin
               if (inner_q != '0) begin
                  state_nxt = S_INNER;
               end else begin
                  state_nxt = last_x ? S_DONE : S_OUTER;
               end
            end
         end
         S_INNER: begin
            if (!pause && last_y) begin
               state_nxt = last_x ? S_DONE : S_OUTER;
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_comb begin
      act1 = 1'b0;
      act2 = 1'b0;
      busy = 1'b0;
      done = 1'b0;
      case (state)
         S_OUTER: begin
            act1 = !pause;
            busy = 1'b1;
         end
         S_INNER: begin
            act2 = !pause;
            busy = 1'b1;
         end
         S_DONE: begin
            done = 1'b1;
         end
         default: begin
            done = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         outer_q  <= '0;
         inner_q  <= '0;
         x        <= '0;
         y        <= '0;
         act1_cnt <= '0;
         act2_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  outer_q  <= outer_n;
                  inner_q  <= inner_n;
                  x        <= '0;
                  y        <= '0;
                  act1_cnt <= '0;
                  act2_cnt <= '0;
               end
            end
            S_OUTER: begin
               if (!pause) begin
                  act1_cnt <= act1_cnt + ONE_A;
                  y        <= '0;
                  if ((inner_q == '0) && !last_x) begin
                     x <= x + ONE_C;
                  end
               end
            end
            S_INNER: begin
               // y stays on the last inner index when the pass ends.
               if (!pause) begin
                  act2_cnt <= act2_cnt + ONE_A;
                  if (last_y) begin
                     if (!last_x) begin
                        x <= x + ONE_C;
                     end
                  end else begin
                     y <= y + ONE_C;
                  end
               end
            end
            S_DONE: begin
`ifdef NLS_DONE_CLEAR_EN
               x        <= '0;
               y        <= '0;
               act1_cnt <= '0;
               act2_cnt <= '0;
`else
               x        <= x;
`endif
            end
            default: begin
               x <= x;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nested_loop_seq.sv
// tb/tb_nested_loop_seq.sv - scoreboard bench for nested_loop_seq
// Honours NLS_DONE_CLEAR_EN for the post-done expectations.
module tb_nested_loop_seq;

   localparam int CNT_W = 8;
   localparam int ACC_W = 16;

   typedef struct {
      int o; int i; int p0; int plen; bit abort;
      int done_rel; int a1; int a2; int x; int y; bit busy;
   } vec_t;

   typedef struct {
      int   base;
      vec_t v;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             pause;
   logic [CNT_W-1:0] outer_n;
   logic [CNT_W-1:0] inner_n;
   logic [CNT_W-1:0] x;
   logic [CNT_W-1:0] y;
   logic             act1;
   logic             act2;
   logic [ACC_W-1:0] act1_cnt;
   logic [ACC_W-1:0] act2_cnt;
   logic             busy;
   logic             done;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   vec_t vecs[$];

   nested_loop_seq #(.CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
      .clk(clk), .rst(rst), .start(start), .pause(pause),
      .outer_n(outer_n), .inner_n(inner_n), .x(x), .y(y),
      .act1(act1), .act2(act2), .act1_cnt(act1_cnt), .act2_cnt(act2_cnt),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: tallies strobes per run and pops the scoreboard on each done.
   int   t1 = 0, t2 = 0;
   bit   bseen = 1'b0;
   bit   post_pend = 1'b0;
   exp_t post_e;
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         t1 = 0; t2 = 0; bseen = 1'b0; post_pend = 1'b0;
      end else begin
         if (post_pend) begin
            post_pend = 1'b0;
`ifdef NLS_DONE_CLEAR_EN
            chk("post_act1_cnt", act1_cnt, 0);
            chk("post_act2_cnt", act2_cnt, 0);
            chk("post_x", x, 0);
            chk("post_y", y, 0);
`else
            chk("post_act1_cnt", act1_cnt, post_e.v.a1);
            chk("post_act2_cnt", act2_cnt, post_e.v.a2);
            chk("post_x", x, post_e.v.x);
            chk("post_y", y, post_e.v.y);
`endif
         end
         if (act1) t1++;
         if (act2) t2++;
         if (busy) bseen = 1'b1;
         if (pause && busy) chk("pause_strobe", {act1, act2}, 0);
         if (done) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("done_cycle", cyc - e.base, e.v.done_rel);
               chk("act1_cnt", act1_cnt, e.v.a1);
               chk("act2_cnt", act2_cnt, e.v.a2);
               chk("act1_strobes", t1, e.v.a1);
               chk("act2_strobes", t2, e.v.a2);
               chk("x_final", x, e.v.x);
               chk("y_final", y, e.v.y);
               chk("busy_seen", bseen, e.v.busy);
               post_e = e;
               post_pend = 1'b1;
            end
            t1 = 0; t2 = 0; bseen = 1'b0;
         end
      end
   end

   task automatic check_all_zero(input string tag);
      chk({tag, "_x"}, x, 0);
      chk({tag, "_y"}, y, 0);
      chk({tag, "_act1_cnt"}, act1_cnt, 0);
      chk({tag, "_act2_cnt"}, act2_cnt, 0);
      chk({tag, "_flags"}, {busy, done, act1, act2}, 0);
   endtask

   // Drives one run; start is held for two cycles and the bounds are
   // scrambled once latched, both of which the DUT must ignore.
   task automatic run(input vec_t v);
      int   base;
      int   rel;
      bit   fin;
      exp_t e;
      @(posedge clk); #1;
      base = cyc;
      if (!v.abort) begin
         e.base = base;
         e.v = v;
         sb.push_back(e);
      end
      fin = 1'b0;
      for (int n = 0; n < 4000 && !fin; n++) begin
         rel     = cyc - base;
         start   = (rel <= 1);
         outer_n = (rel == 0) ? CNT_W'(v.o) : ~CNT_W'(v.o);
         inner_n = (rel == 0) ? CNT_W'(v.i) : ~CNT_W'(v.i);
         pause   = (v.plen > 0) && (rel >= v.p0) && (rel < v.p0 + v.plen);
         if (v.abort && rel == 50) begin
            #2 rst = 1'b1;
            #1 check_all_zero("abort");
            @(posedge clk); #1;
            rst = 1'b0; start = 1'b0; pause = 1'b0;
            fin = 1'b1;
         end else if (!v.abort && rel >= 2 && sb.size() == 0) begin
            fin = 1'b1;
         end else begin
            @(posedge clk); #1;
         end
      end
      if (!fin) begin
         chk("timeout", sb.size(), 0);
         sb.delete();
      end
      start = 1'b0;
      pause = 1'b0;
      repeat (3) @(posedge clk);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; pause = 1'b0; outer_n = '0; inner_n = '0;
      #3 check_all_zero("reset");
      @(posedge clk); #1 rst = 1'b0;

      //              o    i  p0 plen abort done  a1   a2   x    y  busy
      vecs.push_back('{10,  10, 0, 0, 1'b0, 111, 10, 100, 9,   9, 1'b1});
      vecs.push_back('{3,   0,  0, 0, 1'b0, 4,   3,  0,   2,   0, 1'b1});
      vecs.push_back('{0,   5,  0, 0, 1'b0, 1,   0,  0,   0,   0, 1'b0});
      vecs.push_back('{2,   4,  3, 3, 1'b0, 14,  2,  8,   1,   3, 1'b1});
      vecs.push_back('{3,   0,  2, 2, 1'b0, 6,   3,  0,   2,   0, 1'b1});
      vecs.push_back('{2,   2,  0, 0, 1'b0, 7,   2,  4,   1,   1, 1'b1});
      vecs.push_back('{1,   1,  0, 0, 1'b0, 3,   1,  1,   0,   0, 1'b1});
      vecs.push_back('{10,  10, 0, 0, 1'b1, 0,   0,  0,   0,   0, 1'b1});
      vecs.push_back('{10,  10, 0, 0, 1'b0, 111, 10, 100, 9,   9, 1'b1});
      vecs.push_back('{1,   255,0, 0, 1'b0, 257, 1,  255, 0, 254, 1'b1});
      vecs.push_back('{255, 1,  0, 0, 1'b0, 511, 255,255, 254, 0, 1'b1});

      foreach (vecs[k]) run(vecs[k]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/nested_loop_seq.md
NESTED_LOOP_SEQ -- requirements
Module: nested_loop_seq

Interface
REQ-001 SHALL have parameter CNT_W, default 8, loop-bound and index width.
REQ-002 SHALL have parameter ACC_W, default 16, action-counter width.
REQ-003 SHALL have port clk, input, 1, the single clock, all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-005 SHALL have port start, input, 1, run request, sampled only in IDLE.
REQ-006 SHALL have port pause, input, 1, freezes the run while high.
REQ-007 SHALL have port outer_n, input, CNT_W, outer iteration count, latched at start.
REQ-008 SHALL have port inner_n, input, CNT_W, inner iterations per outer pass, latched at start.
REQ-009 SHALL have ports x and y, output, CNT_W each, current outer and inner indices.
REQ-010 SHALL have ports act1 and act2, output, 1 each, one-cycle action strobes.
REQ-011 SHALL have ports act1_cnt and act2_cnt, output, ACC_W each, action totals for the run.
REQ-012 SHALL have ports busy and done, output, 1 each: busy high in OUTER/INNER; done is a one-cycle strobe.

Function
REQ-013 SHALL implement four states: IDLE, OUTER, INNER, DONE.
REQ-014 IDLE with start=1 SHALL latch outer_n/inner_n, clear x, y, act1_cnt, act2_cnt, and go to OUTER; if latched outer_n=0, SHALL go directly to DONE instead.
REQ-015 OUTER SHALL assert act1 for that cycle, increment act1_cnt, clear y, then go to INNER if inner_n>0; otherwise advance x per REQ-017.
REQ-016 INNER SHALL assert act2 each cycle, increment act2_cnt, and increment y; at y=inner_n-1 it SHALL advance x per REQ-017.
REQ-017 Advancing x SHALL go to DONE when x=outer_n-1 (x held), else increment x and go to OUTER.
REQ-018 DONE SHALL assert done for exactly one cycle, then return to IDLE; x, y, and counts SHALL hold their final values in IDLE.
REQ-019 With start at edge k, done SHALL be high in cycle k+1+outer_n*(1+inner_n); total strobes: outer_n act1 and outer_n*inner_n act2.
REQ-020 pause=1 in OUTER/INNER SHALL stall state, indices, and counters, and force act1/act2 low; pause SHALL have no effect in IDLE/DONE.
REQ-021 start SHALL be ignored in OUTER, INNER, and DONE; outer_n/inner_n changes after latch SHALL have no effect.
REQ-022 act1_cnt/act2_cnt SHALL wrap modulo 2^ACC_W; index compares SHALL be CNT_W-wide, unsigned.

Reset
REQ-023 While rst is high, SHALL force state IDLE and all outputs plus latched bounds to 0, independent of clk.
REQ-024 rst asserted mid-run SHALL abort with no done strobe; first start after release begins a fresh run.

Configuration
REQ-025 Macro NLS_DONE_CLEAR_EN, when defined, SHALL make DONE clear act1_cnt, act2_cnt, x, y on the done cycle's exit (0 in IDLE); when undefined, values SHALL hold until next start.

Verification
REQ-026 outer_n=10, inner_n=10, start at cycle 0 -> 10 act1, 100 act2, done at cycle 111, act1_cnt=10, act2_cnt=100 (macro undefined).
REQ-027 outer_n=3, inner_n=0 -> act1 at cycles 1,2,3; no act2; done at cycle 4; act2_cnt=0.
REQ-028 outer_n=0, inner_n=5 -> done at cycle 1, no strobes, busy never high.
REQ-029 outer_n=2, inner_n=4, pause high for cycles 3-5 -> done delayed from cycle 11 to 14, act2_cnt=8, no strobes during pause.
REQ-030 rst pulsed at cycle 50 of a 10x10 run -> all outputs 0 immediately, no done; restart completes normally.
REQ-031 NLS_DONE_CLEAR_EN defined, 2x2 run -> act1_cnt=2, act2_cnt=4 during done cycle, both 0 the following cycle.
